// File: rtl/snake_pkg.sv
// snake_pkg: shared direction codes, EPP register map and EPP port state encoding.
package snake_pkg;

   typedef enum logic [3:0] {
      EMPTY = 4'b0000,
      RIGHT = 4'b0001,
      UP    = 4'b0010,
      LEFT  = 4'b0100,
      DOWN  = 4'b1000,
      APPLE = 4'b1111
   } dir_t;

   localparam logic [7:0] EPP_REG_DIR      = 8'h00;
   localparam logic [7:0] EPP_REG_STATUS   = 8'h01;
   localparam logic [7:0] EPP_REG_SCORE_LO = 8'h02;
   localparam logic [7:0] EPP_REG_SCORE_HI = 8'h03;

   typedef enum logic [2:0] {
      S_IDLE,
      S_AWR,
      S_ARD,
      S_DWR,
      S_DRD,
      S_ACK
   } epp_state_t;

   // Only the four movement codes are valid commands for the game.
   function automatic logic is_dir(input logic [3:0] v);
      return v == RIGHT || v == UP || v == LEFT || v == DOWN;
   endfunction

endpackage

// File: rtl/epp_sync.sv
// epp_sync: SYNC_STAGES-deep synchronizer for host strobes, idle-high out of reset.
module epp_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;

   always_comb sync_d = {sync_q[SYNC_STAGES-2:0], d};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) sync_q <= '1;
      else      sync_q <= sync_d;
   end

   assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/epp_port.sv
// epp_port: EPP slave for the snake host link; address register, direction command, status/score reads.
// EPP_READBACK_EN enables status and score reads; otherwise data reads return 0x00.
module epp_port
   import snake_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        epp_astb,
   input  logic        epp_dstb,
   input  logic        epp_write,
   input  logic [7:0]  epp_db_in,
   output logic [7:0]  epp_db_out,
   output logic        epp_db_oe,
   output logic        epp_wait,
   output logic [3:0]  epp_data,
   output logic        epp_wr,
   input  logic        game_over,
   input  logic [15:0] number
);

   logic       astb_s, dstb_s, write_s;
   logic [7:0] rd_data;

   epp_state_t state_q, state_d;
   logic [7:0] addr_q, addr_d;
   logic [7:0] db_out_q, db_out_d;
   logic [3:0] data_q, data_d;
   logic       oe_q, oe_d;
   logic       wait_q, wait_d;
   logic       wr_q, wr_d;
   logic       astb_txn_q, astb_txn_d;

   epp_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_astb  (.clk(clk), .rst(rst), .d(epp_astb),  .q(astb_s));
   epp_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_dstb  (.clk(clk), .rst(rst), .d(epp_dstb),  .q(dstb_s));
   epp_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_write (.clk(clk), .rst(rst), .d(epp_write), .q(write_s));

`ifdef EPP_READBACK_EN
   assign rd_data = addr_q == EPP_REG_STATUS   ? {7'b0, game_over} :
                    addr_q == EPP_REG_SCORE_LO ? number[7:0]       :
                    addr_q == EPP_REG_SCORE_HI ? number[15:8]      : 8'h00;
`else
   logic unused_readback;
   assign unused_readback = ^{game_over, number};
   assign rd_data = 8'h00;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         addr_q     <= 8'h00;
         db_out_q   <= 8'h00;
         data_q     <= RIGHT;
         oe_q       <= 1'b0;
         wait_q     <= 1'b0;
         wr_q       <= 1'b0;
         astb_txn_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         db_out_q   <= db_out_d;
         data_q     <= data_d;
         oe_q       <= oe_d;
         wait_q     <= wait_d;
         wr_q       <= wr_d;
         astb_txn_q <= astb_txn_d;
      end
   end

   // Address strobe takes priority when both strobes are seen low together.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (!astb_s)      state_d = write_s ? S_ARD : S_AWR;
            else if (!dstb_s) state_d = write_s ? S_DRD : S_DWR;
         end
         S_AWR, S_ARD, S_DWR, S_DRD: state_d = S_ACK;
         S_ACK:   if (astb_txn_q ? astb_s : dstb_s) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Write actions and read snapshots happen on the detection cycle so wr/wait or oe appear one cycle later.
   always_comb begin
      addr_d     = addr_q;
      db_out_d   = db_out_q;
      data_d     = data_q;
      oe_d       = oe_q;
      wait_d     = wait_q;
      wr_d       = 1'b0;
      astb_txn_d = astb_txn_q;
      if (state_q == S_IDLE) begin
         astb_txn_d = !astb_s;
         if (state_d == S_AWR) begin
            addr_d = epp_db_in;
            wait_d = 1'b1;
         end
         if (state_d == S_DWR) begin
            wait_d = 1'b1;
            wr_d   = addr_q == EPP_REG_DIR && is_dir(epp_db_in[3:0]);
            if (wr_d) data_d = epp_db_in[3:0];
         end
         if (state_d == S_ARD) begin
            db_out_d = addr_q;
            oe_d     = 1'b1;
         end
         if (state_d == S_DRD) begin
            db_out_d = rd_data;
            oe_d     = 1'b1;
         end
      end
      if (state_q == S_ARD || state_q == S_DRD) wait_d = 1'b1;
      if (state_q == S_ACK && state_d == S_IDLE) begin
         wait_d = 1'b0;
         oe_d   = 1'b0;
      end
   end

   assign epp_db_out = db_out_q;
   assign epp_db_oe  = oe_q;
   assign epp_wait   = wait_q;
   assign epp_data   = data_q;
   assign epp_wr     = wr_q;

endmodule

// File: tb/tb_epp_port.sv
// tb_epp_port: directed host-cycle bench for epp_port with hand-computed expectations.
module tb_epp_port;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        epp_astb = 1'b1;
   logic        epp_dstb = 1'b1;
   logic        epp_write = 1'b0;
   logic [7:0]  epp_db_in = 8'h00;
   logic [7:0]  epp_db_out;
   logic        epp_db_oe;
   logic        epp_wait;
   logic [3:0]  epp_data;
   logic        epp_wr;
   logic        game_over = 1'b0;
   logic [15:0] number = 16'h0000;

   int tests = 0;
   int failures = 0;
   int wr_cycles = 0;
   logic [7:0] rd;

`ifdef EPP_READBACK_EN
   localparam logic [7:0] EXP_LO = 8'h34, EXP_HI = 8'h12, EXP_ST = 8'h01;
`else
   localparam logic [7:0] EXP_LO = 8'h00, EXP_HI = 8'h00, EXP_ST = 8'h00;
`endif

   epp_port dut (
      .clk(clk), .rst(rst),
      .epp_astb(epp_astb), .epp_dstb(epp_dstb), .epp_write(epp_write),
      .epp_db_in(epp_db_in), .epp_db_out(epp_db_out), .epp_db_oe(epp_db_oe),
      .epp_wait(epp_wait), .epp_data(epp_data), .epp_wr(epp_wr),
      .game_over(game_over), .number(number)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (epp_wr) wr_cycles++;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      tests++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One full host cycle; mid replaces number once read data is already on the bus.
   task automatic host(input string tag, input logic is_addr, input logic is_rd, input logic [7:0] wd,
                       input logic [15:0] mid, input int exp_wr, output logic [7:0] rdata);
      int n;
      int w0;
      logic prev_oe;
      n = 0;
      prev_oe = 1'b0;
      w0 = wr_cycles;
      @(negedge clk);
      epp_write = is_rd;
      epp_db_in = wd;
      if (is_addr) epp_astb = 1'b0;
      else         epp_dstb = 1'b0;
      forever begin
         @(negedge clk);
         n++;
         if (epp_wait || n > 40) break;
         prev_oe = epp_db_oe;
         if (epp_db_oe) number = mid;
      end
      check({tag, "_wait_up"}, epp_wait, 1);
      check({tag, "_wr_with_wait"}, epp_wr, exp_wr[0]);
      check({tag, "_oe_lead"}, prev_oe, is_rd);
      rdata = epp_db_out;
      repeat (5) @(negedge clk);
      check({tag, "_held_ack"}, epp_wait, 1);
      check({tag, "_held_oe"}, epp_db_oe, is_rd);
      check({tag, "_held_data"}, epp_db_out, rdata);
      epp_astb = 1'b1;
      epp_dstb = 1'b1;
      n = 0;
      while (epp_wait && n < 20) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_wait_down"}, epp_wait, 0);
      check({tag, "_oe_down"}, epp_db_oe, 0);
      check({tag, "_wr_count"}, 16'(wr_cycles - w0), 16'(exp_wr));
   endtask

   initial begin
      int n;
      int w0;
      #23;
      check("rst_wait", epp_wait, 0);
      check("rst_oe", epp_db_oe, 0);
      check("rst_dbout", epp_db_out, 8'h00);
      check("rst_data", epp_data, 4'b0001);
      check("rst_wr", epp_wr, 0);
      rst = 1'b1;
      repeat (3) @(negedge clk);

      host("aw0", 1, 0, 8'h00, number, 0, rd);
      host("ar0", 1, 1, 8'h00, number, 0, rd);
      check("ar0_val", rd, 8'h00);
      host("dw_left", 0, 0, 8'h04, number, 1, rd);
      check("dw_left_data", epp_data, 4'b0100);
      host("dw_bad", 0, 0, 8'h06, number, 0, rd);
      check("dw_bad_data", epp_data, 4'b0100);
      host("dw_up", 0, 0, 8'h02, number, 1, rd);
      check("dw_up_data", epp_data, 4'b0010);
      host("dr_dir", 0, 1, 8'h00, number, 0, rd);
      check("dr_dir_val", rd, 8'h00);

      host("aw2", 1, 0, 8'h02, number, 0, rd);
      number = 16'h1234;
      host("dr_lo", 0, 1, 8'h00, 16'hABCD, 0, rd);
      check("dr_lo_val", rd, EXP_LO);
      host("aw3", 1, 0, 8'h03, number, 0, rd);
      number = 16'h1234;
      host("dr_hi", 0, 1, 8'h00, 16'hABCD, 0, rd);
      check("dr_hi_val", rd, EXP_HI);

      host("aw1", 1, 0, 8'h01, number, 0, rd);
      game_over = 1'b1;
      host("dr_st", 0, 1, 8'h00, number, 0, rd);
      check("dr_st_val", rd, EXP_ST);

      host("aw7", 1, 0, 8'h07, number, 0, rd);
      host("dr_7", 0, 1, 8'h00, number, 0, rd);
      check("dr_7_val", rd, 8'h00);
      host("dw_7", 0, 0, 8'h01, number, 0, rd);
      check("dw_7_data", epp_data, 4'b0010);
      host("ar7", 1, 1, 8'h00, number, 0, rd);
      check("ar7_val", rd, 8'h07);

      // Reset while a direction write sits in ACK.
      host("aw0b", 1, 0, 8'h00, number, 0, rd);
      @(negedge clk);
      epp_write = 1'b0;
      epp_db_in = 8'h08;
      epp_dstb = 1'b0;
      n = 0;
      while (!epp_wait && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("rstw_wait_up", epp_wait, 1);
      check("rstw_data_pre", epp_data, 4'b1000);
      repeat (2) @(negedge clk);
      w0 = wr_cycles;
      #2 rst = 1'b0;
      #1;
      check("rstw_wait_async", epp_wait, 0);
      check("rstw_oe_async", epp_db_oe, 0);
      epp_dstb = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (4) @(negedge clk);
      check("rstw_no_wr", 16'(wr_cycles - w0), 0);
      check("rstw_data", epp_data, 4'b0001);
      host("ar_after", 1, 1, 8'h00, number, 0, rd);
      check("ar_after_val", rd, 8'h00);

      // Reset while an address read drives the bus.
      host("aw5", 1, 0, 8'h05, number, 0, rd);
      @(negedge clk);
      epp_write = 1'b1;
      epp_astb = 1'b0;
      n = 0;
      while (!epp_wait && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("rstr_oe_up", epp_db_oe, 1);
      check("rstr_val", epp_db_out, 8'h05);
      #2 rst = 1'b0;
      #1;
      check("rstr_oe_async", epp_db_oe, 0);
      check("rstr_wait_async", epp_wait, 0);
      check("rstr_dbout", epp_db_out, 8'h00);
      epp_astb = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
